// File: rtl/seq_controller.sv
// seq_controller: eight-phase instruction sequencer for the 5-bit-address
// teaching CPU. Drives the address-mux select plus memory, IR, PC and
// accumulator strobes from the current phase, opcode and zero flag.
module seq_controller #(
  parameter int unsigned OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           sel,
  output logic           mem_rd,
  output logic           load_ir,
  output logic           inc_pc,
  output logic           load_pc,
  output logic           load_ac,
  output logic           mem_wr,
  output logic           data_e,
  output logic           halt,
  output logic [2:0]     phase
);

  localparam logic [OPW-1:0] OP_HLT = OPW'(0);
  localparam logic [OPW-1:0] OP_SKZ = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_LDA = OPW'(5);
  localparam logic [OPW-1:0] OP_STO = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP = OPW'(7);

  // Phase encodings 0..7 match the debug phase value; HALTED sits outside
  // that range and reports phase 7.
  typedef enum logic [3:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_IDLE       = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALTED     = 4'd8
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_is_hlt;
  logic w_is_skz;
  logic w_is_sto;
  logic w_is_jmp;
  logic w_aluop;

  assign w_is_hlt = (opcode == OP_HLT);
  assign w_is_skz = (opcode == OP_SKZ);
  assign w_is_sto = (opcode == OP_STO);
  assign w_is_jmp = (opcode == OP_JMP);
  assign w_aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

  // State register with asynchronous return to INST_ADDR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_INST_ADDR;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: one phase per edge, HLT diverts OP_ADDR into HALTED.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_INST_ADDR:  w_next = S_INST_FETCH;
      S_INST_FETCH: w_next = S_INST_LOAD;
      S_INST_LOAD:  w_next = S_IDLE;
      S_IDLE:       w_next = S_OP_ADDR;
      S_OP_ADDR:    w_next = w_is_hlt ? S_HALTED : S_OP_FETCH;
      S_OP_FETCH:   w_next = S_ALU_OP;
      S_ALU_OP:     w_next = S_STORE;
      S_STORE:      w_next = S_INST_ADDR;
      S_HALTED:     w_next = S_HALTED;
      default:      w_next = S_INST_ADDR;
    endcase
  end

  // Output decode of registered state qualified by opcode and zero.
  always_comb begin
    sel     = 1'b0;
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    load_ac = 1'b0;
    mem_wr  = 1'b0;
    data_e  = 1'b0;
    halt    = 1'b0;
    phase   = r_state[2:0];
    unique case (r_state)
      S_INST_ADDR: begin
        sel = 1'b1;
      end
      S_INST_FETCH: begin
        sel    = 1'b1;
        mem_rd = 1'b1;
      end
      S_INST_LOAD, S_IDLE: begin
        sel     = 1'b1;
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      S_OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = w_is_hlt;
      end
      S_OP_FETCH: begin
        mem_rd = w_aluop;
      end
      S_ALU_OP: begin
        mem_rd  = w_aluop;
        data_e  = w_is_sto;
        inc_pc  = w_is_skz & zero;
        load_pc = w_is_jmp;
      end
      S_STORE: begin
        mem_rd  = w_aluop;
        load_ac = w_aluop;
        inc_pc  = w_is_jmp;
        load_pc = w_is_jmp;
        mem_wr  = w_is_sto;
        data_e  = w_is_sto;
      end
      S_HALTED: begin
        halt  = 1'b1;
        phase = 3'd7;
      end
      default: begin
        sel = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller. Output vectors are packed as
// {sel, mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, data_e, halt}.
module tb_seq_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, data_e, halt;
  logic [2:0] phase;
  logic [8:0] outs;

  int n_checks;
  int n_fail;

  seq_controller #(.OPW(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .zero    (zero),
    .sel     (sel),
    .mem_rd  (mem_rd),
    .load_ir (load_ir),
    .inc_pc  (inc_pc),
    .load_pc (load_pc),
    .load_ac (load_ac),
    .mem_wr  (mem_wr),
    .data_e  (data_e),
    .halt    (halt),
    .phase   (phase)
  );

  assign outs = {sel, mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, data_e, halt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    opcode = 3'd2;
    zero = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (phase !== 3'd0 || outs !== 9'b100000000) begin
      n_fail++;
      $display("FAIL reset_hold: phase=%0d outs=%b required phase=0 outs=100000000", phase, outs);
    end
    rst = 1'b0;
    n_checks++;
    if (phase !== 3'd0 || outs !== 9'b100000000) begin
      n_fail++;
      $display("FAIL reset_release: phase=%0d outs=%b required phase=0 outs=100000000", phase, outs);
    end
  endtask

  task automatic test_add();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
            9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000};
    opcode = 3'd2;
    zero = 1'b0;
    for (int p = 0; p < 8; p++) begin
      n_checks++;
      if (phase !== 3'(p) || outs !== exp[p]) begin
        n_fail++;
        $display("FAIL add_p%0d: phase=%0d outs=%b required phase=%0d outs=%b", p, phase, outs, p, exp[p]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (phase !== 3'd0) begin
      n_fail++;
      $display("FAIL add_wrap: phase=%0d required 0", phase);
    end
  endtask

  // Opcode is junk in phases 0-2 and zero toggles outside ALU_OP; neither may matter.
  task automatic test_skz();
    logic [8:0] exp1 [8];
    logic [8:0] exp0 [8];
    exp1 = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
             9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000};
    exp0 = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
             9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000};
    for (int p = 0; p < 8; p++) begin
      opcode = (p < 3) ? 3'(p + 5) : 3'd1;
      zero = (p == 6) ? 1'b1 : 1'b0;
      #1;
      n_checks++;
      if (phase !== 3'(p) || outs !== exp1[p]) begin
        n_fail++;
        $display("FAIL skz_z1_p%0d: phase=%0d outs=%b required phase=%0d outs=%b", p, phase, outs, p, exp1[p]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    for (int p = 0; p < 8; p++) begin
      opcode = (p < 3) ? 3'(7 - p) : 3'd1;
      zero = (p == 6) ? 1'b0 : 1'b1;
      #1;
      n_checks++;
      if (phase !== 3'(p) || outs !== exp0[p]) begin
        n_fail++;
        $display("FAIL skz_z0_p%0d: phase=%0d outs=%b required phase=%0d outs=%b", p, phase, outs, p, exp0[p]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    zero = 1'b0;
  endtask

  task automatic test_jmp();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
            9'b000100000, 9'b000000000, 9'b000010000, 9'b000110000};
    opcode = 3'd7;
    zero = 1'b1;
    for (int p = 0; p < 8; p++) begin
      n_checks++;
      if (phase !== 3'(p) || outs !== exp[p]) begin
        n_fail++;
        $display("FAIL jmp_p%0d: phase=%0d outs=%b required phase=%0d outs=%b", p, phase, outs, p, exp[p]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    zero = 1'b0;
  endtask

  task automatic test_sto();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
            9'b000100000, 9'b000000000, 9'b000000010, 9'b000000110};
    opcode = 3'd6;
    for (int p = 0; p < 8; p++) begin
      n_checks++;
      if (phase !== 3'(p) || outs !== exp[p]) begin
        n_fail++;
        $display("FAIL sto_p%0d: phase=%0d outs=%b required phase=%0d outs=%b", p, phase, outs, p, exp[p]);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_hlt();
    logic [8:0] exp [5];
    exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000, 9'b000100001};
    opcode = 3'd0;
    for (int p = 0; p < 5; p++) begin
      n_checks++;
      if (phase !== 3'(p) || outs !== exp[p]) begin
        n_fail++;
        $display("FAIL hlt_p%0d: phase=%0d outs=%b required phase=%0d outs=%b", p, phase, outs, p, exp[p]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    for (int c = 0; c < 20; c++) begin
      opcode = 3'(c);
      zero = c[0];
      #1;
      n_checks++;
      if (phase !== 3'd7 || outs !== 9'b000000001) begin
        n_fail++;
        $display("FAIL halted_c%0d: phase=%0d outs=%b required phase=7 outs=000000001", c, phase, outs);
      end
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (phase !== 3'd0 || outs !== 9'b100000000) begin
      n_fail++;
      $display("FAIL hlt_async_rst: phase=%0d outs=%b required phase=0 outs=100000000", phase, outs);
    end
    @(negedge clk);
    rst = 1'b0;
    opcode = 3'd2;
    zero = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (phase !== 3'd1 || outs !== 9'b110000000) begin
      n_fail++;
      $display("FAIL hlt_restart: phase=%0d outs=%b required phase=1 outs=110000000", phase, outs);
    end
    // Finish this ADD instruction so the next task starts in phase 0.
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_async_rst_mid_alu();
    opcode = 3'd7;
    zero = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (phase !== 3'd6 || load_pc !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_alu_pre: phase=%0d load_pc=%b required phase=6 load_pc=1", phase, load_pc);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (load_pc !== 1'b0 || phase !== 3'd0 || outs !== 9'b100000000) begin
      n_fail++;
      $display("FAIL mid_alu_rst: phase=%0d outs=%b required phase=0 outs=100000000", phase, outs);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (phase !== 3'd1 || outs !== 9'b110000000) begin
      n_fail++;
      $display("FAIL mid_alu_restart: phase=%0d outs=%b required phase=1 outs=110000000", phase, outs);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    opcode = 3'd0;
    zero = 1'b0;
    test_reset();
    test_add();
    test_skz();
    test_jmp();
    test_sto();
    test_hlt();
    test_async_rst_mid_alu();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
Name: seq_controller

Overview:
- Eight-phase instruction sequencer for the 5-bit-address teaching CPU.
- Sits directly upstream of the address multiplexor and drives its `sel` input:
  - `sel`=1 selects the program-counter address (mux `in1`).
  - `sel`=0 selects the instruction-register operand address (mux `in0`).
- Also generates memory, register and program-counter strobes from the current phase, the opcode and the accumulator-zero flag.

Parameters:
- OPW, 3, opcode width; fixed encoding below requires 3.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  OPW  instruction opcode from instruction register (stable from IDLE onward).
- zero  input  1  accumulator-is-zero flag.
- sel  output  1  address mux select (1 = PC, 0 = IR operand).
- mem_rd  output  1  memory read strobe.
- load_ir  output  1  instruction register load.
- inc_pc  output  1  program counter increment.
- load_pc  output  1  program counter load.
- load_ac  output  1  accumulator load.
- mem_wr  output  1  memory write strobe.
- data_e  output  1  data bus drive enable (store path).
- halt  output  1  processor halted.
- phase  output  3  current phase index, for debug.

Behaviour:
- Interface: one clock, `clk`; `rst` is asynchronous and active-high.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = ADD|AND|XOR|LDA.
- States (`phase` value):
  - INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
  - HALTED: a separate ninth state; `phase` reads 7 while in it.
- Reset:
  - `rst` high forces state INST_ADDR immediately, independent of `clk`, including mid-instruction.
  - Outputs during and after reset: `sel`=1, all strobes 0, `halt`=0, `phase`=0.
  - First edge after deassertion moves to INST_FETCH.
- Transitions:
  - Each state advances one step per rising edge: 0→1→…→7→0.
  - Exception: in OP_ADDR with opcode==HLT, the next state is HALTED.
  - HALTED is held until `rst`.
- Outputs are combinational decode of the registered state plus `opcode`/`zero` (Moore-with-qualifiers), so they are glitch-tolerant only within a cycle.
- Per state (strobes not listed are 0):
  - INST_ADDR: `sel`=1.
  - INST_FETCH: `sel`=1, `mem_rd`=1.
  - INST_LOAD: `sel`=1, `mem_rd`=1, `load_ir`=1.
  - IDLE: `sel`=1, `mem_rd`=1, `load_ir`=1.
  - OP_ADDR: `sel`=0, `inc_pc`=1, `halt`=(opcode==HLT).
  - OP_FETCH: `sel`=0, `mem_rd`=ALUOP.
  - ALU_OP:
    - `sel`=0, `mem_rd`=ALUOP, `data_e`=(STO).
    - `inc_pc`=(SKZ & `zero`), `load_pc`=(JMP).
  - STORE:
    - `sel`=0, `mem_rd`=ALUOP, `load_ac`=ALUOP.
    - `inc_pc`=(JMP), `load_pc`=(JMP).
    - `mem_wr`=(STO), `data_e`=(STO).
  - HALTED: `halt`=1, `sel`=0, all other strobes 0.
- Boundary conditions:
  - `zero` is sampled only in ALU_OP.
  - SKZ with `zero`=0 yields no extra increment.
  - `opcode` is ignored in phases 0–3, so changes there have no effect.
  - `mem_rd` and `mem_wr` are never both 1.
  - `load_pc`=1 only for JMP.
  - `inc_pc` is never 1 in phases 0–3.
- Instruction latency: exactly 8 cycles; no stall input.
- Unused `opcode` values: none (3-bit field fully decoded).

Test Plan:
- Reset, then deassert `rst`, run 8 edges with opcode=ADD, `zero`=0:
  - `phase` sequence 0..7,0.
  - `mem_rd` high in phases 1,2,3,5,6,7.
  - `load_ac`=1 only in phase 7.
  - `inc_pc`=1 only in phase 4.
  - `sel`=1 in phases 0–3, 0 in phases 4–7.
- opcode=SKZ, run two instructions:
  - With `zero`=1: `inc_pc`=1 in phases 4 and 6.
  - With `zero`=0: `inc_pc`=1 in phase 4 only.
  - `mem_rd`=0 in phases 5–7 in both cases.
- opcode=JMP:
  - `load_pc`=1 in phases 6 and 7.
  - `inc_pc`=1 in phases 4 and 7.
  - `mem_wr`=0 throughout.
- opcode=STO:
  - `data_e`=1 in phases 6–7.
  - `mem_wr`=1 in phase 7 only.
  - `mem_rd`=0 in phases 4–7.
  - `load_ac`=0.
- opcode=HLT:
  - `halt`=1 in OP_ADDR.
  - HALTED is entered next edge and held for 20 cycles: `halt`=1, other strobes 0.
  - Asynchronous `rst` pulse returns `phase`=0, `halt`=0, `sel`=1 before the next clock edge.
- Assert `rst` asynchronously mid-ALU_OP with opcode=JMP:
  - `load_pc` drops to 0 immediately.
  - `phase`=0.
  - After release the sequence restarts at INST_FETCH.
